// File: rtl/uart_axis_pkg.sv
// Shared defaults for the UART <-> AXI4-Stream adapters (RX bridge and TX path).
package uart_axis_pkg;

  localparam int unsigned DefaultDataBits = 8;
  localparam logic [7:0]  DefaultDelim    = 8'h0A;
  localparam int unsigned DropCntW        = 16;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: the head entry is always visible on rd_data.
// Level is tracked by its own counter so pointers can wrap naturally.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             do_wr, do_rd;

  assign empty = (level_q == '0);
  assign full  = (level_q == LvlW'(DEPTH));
  assign level = level_q;

  // A write into a full FIFO is only allowed when the head leaves in the same cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_wr && !rst) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_axis_bridge.sv
// Buffers single-cycle UART RX bytes in a FWFT FIFO and presents them as an AXIS master,
// tagging the delimiter byte with tlast and counting bytes dropped on overflow.
module uart_rx_axis_bridge
  import uart_axis_pkg::*;
#(
  parameter int unsigned          DATA_BITS  = DefaultDataBits,
  parameter int unsigned          FIFO_DEPTH = 16,
  parameter logic [DATA_BITS-1:0] DELIM      = DATA_BITS'(DefaultDelim),
  parameter bit                   DELIM_EN   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          rx_data,
  input  logic                          rx_valid,
  output logic [DATA_BITS-1:0]          m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [DropCntW-1:0]           drop_cnt
);

  logic [DATA_BITS:0]    wr_word, rd_word;
  logic                  full, empty, pop, drop;
  logic                  overflow_q;
  logic [DropCntW-1:0]   drop_cnt_q;

  assign wr_word = {DELIM_EN && (rx_data == DELIM), rx_data};

  sync_fifo_fwft #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rx_valid),
    .wr_data (wr_word),
    .rd_en   (m_axis_tready),
    .rd_data (rd_word),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = rd_word[DATA_BITS-1:0];
  assign m_axis_tlast  = rd_word[DATA_BITS];

  assign pop  = m_axis_tvalid && m_axis_tready;
  assign drop = rx_valid && full && !pop;

  // A drop in the same cycle as ovf_clr wins and restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (ovf_clr) begin
        drop_cnt_q <= DropCntW'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_q <= drop_cnt_q + DropCntW'(1);
      end
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_axis_bridge.sv
// Scoreboard bench for uart_rx_axis_bridge: a behavioural FIFO model runs beside the DUT.
module tb_uart_rx_axis_bridge;

  localparam int unsigned Depth = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tready;
  logic       ovf_clr;

  logic [7:0]  tdata, nd_tdata;
  logic        tvalid, nd_tvalid;
  logic        tlast, nd_tlast;
  logic [4:0]  level, nd_level;
  logic        overflow, nd_overflow;
  logic [15:0] drop_cnt, nd_drop_cnt;

  always #5 clk = ~clk;

  uart_rx_axis_bridge #(
    .DATA_BITS  (8),
    .FIFO_DEPTH (Depth),
    .DELIM      (8'h0A),
    .DELIM_EN   (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .fifo_level    (level),
    .overflow      (overflow),
    .ovf_clr       (ovf_clr),
    .drop_cnt      (drop_cnt)
  );

  // Same stimulus with the delimiter disabled: tlast must never rise.
  uart_rx_axis_bridge #(
    .DATA_BITS  (8),
    .FIFO_DEPTH (Depth),
    .DELIM      (8'h0A),
    .DELIM_EN   (1'b0)
  ) dut_nd (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .m_axis_tdata  (nd_tdata),
    .m_axis_tvalid (nd_tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (nd_tlast),
    .fifo_level    (nd_level),
    .overflow      (nd_overflow),
    .ovf_clr       (ovf_clr),
    .drop_cnt      (nd_drop_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_beats = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard state: expected FIFO contents as {tlast, data}, plus counters.
  logic [8:0]  sb_q[$];
  logic        m_ok = 1'b0;
  logic        m_ovf;
  logic [15:0] m_cnt;
  logic        stall_prev = 1'b0;
  logic [8:0]  stall_word;

  always @(negedge clk) begin
    int  lvl;
    logic pop;
    if (m_ok && !rst) begin
      check("tvalid", tvalid, sb_q.size() != 0);
      check("level", level, sb_q.size());
      check("overflow", overflow, m_ovf);
      check("drop_cnt", drop_cnt, m_cnt);
      if (sb_q.size() != 0) begin
        check("head", {tlast, tdata}, sb_q[0]);
        check("nd_head", {nd_tlast, nd_tdata}, {1'b0, sb_q[0][7:0]});
        if (stall_prev) check("axis_stable", {tlast, tdata}, stall_word);
      end
    end
    if (rst) begin
      sb_q.delete();
      m_ovf      = 1'b0;
      m_cnt      = '0;
      m_ok       = 1'b1;
      stall_prev = 1'b0;
    end else if (m_ok) begin
      lvl        = sb_q.size();
      pop        = (lvl != 0) && tready;
      stall_prev = (lvl != 0) && !tready;
      stall_word = {tlast, tdata};
      if (pop) begin
        void'(sb_q.pop_front());
        n_beats++;
      end
      if (rx_valid && (lvl < Depth || pop)) begin
        sb_q.push_back({rx_data == 8'h0A, rx_data});
      end else if (rx_valid) begin
        m_ovf = 1'b1;
        m_cnt = ovf_clr ? 16'd1 : (m_cnt == 16'hFFFF ? m_cnt : m_cnt + 16'd1);
      end else if (ovf_clr) begin
        m_ovf = 1'b0;
        m_cnt = '0;
      end
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  initial begin
    int b0;
    logic [7:0] seq [3];
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; tready = 1'b0; ovf_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_level", level, 5'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_drop_cnt", drop_cnt, 16'd0);

    // Single byte, one clock latency, then empty.
    tready = 1'b1;
    send(8'h41);
    check("t1_tvalid", tvalid, 1'b1);
    check("t1_tdata", tdata, 8'h41);
    check("t1_tlast", tlast, 1'b0);
    step();
    check("t1_empty", tvalid, 1'b0);
    check("t1_level", level, 5'd0);

    // Delimited packet.
    seq[0] = 8'h48; seq[1] = 8'h69; seq[2] = 8'h0A;
    b0 = n_beats;
    for (int i = 0; i < 3; i++) send(seq[i]);
    repeat (3) step();
    check("t2_beats", n_beats - b0, 3);

    // Stall, fill past depth: one drop.
    tready = 1'b0;
    for (int i = 0; i <= 16; i++) send(8'(i));
    step();
    check("t3_level", level, 5'd16);
    check("t3_overflow", overflow, 1'b1);
    check("t3_drop_cnt", drop_cnt, 16'd1);
    check("t3_head", tdata, 8'h00);
    repeat (4) step();

    // Full with write and handshake in the same cycle: no drop.
    tready = 1'b1;
    send(8'hAA);
    tready = 1'b0;
    check("t4_level", level, 5'd16);
    check("t4_drop_cnt", drop_cnt, 16'd1);
    step();
    tready = 1'b1;
    repeat (17) step();
    check("t4_drained", level, 5'd0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t4_clr_ovf", overflow, 1'b0);
    check("t4_clr_cnt", drop_cnt, 16'd0);

    // Clear coinciding with a drop: drop wins.
    tready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i));
    check("t5_overflow_pre", overflow, 1'b0);
    send(8'h01);
    send(8'h02);
    check("t5_drop_cnt2", drop_cnt, 16'd2);
    ovf_clr = 1'b1;
    send(8'h03);
    ovf_clr = 1'b0;
    check("t5_clr_drop_ovf", overflow, 1'b1);
    check("t5_clr_drop_cnt", drop_cnt, 16'd1);
    ovf_clr = 1'b1;
    tready  = 1'b1;
    step();
    ovf_clr = 1'b0;
    repeat (17) step();
    check("t5_cleared", drop_cnt, 16'd0);

    // Random backpressure, 1000 bytes at one per 4 clocks.
    b0 = n_beats;
    for (int n = 0; n < 1000; n++) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      for (int k = 0; k < 4; k++) begin
        tready = 1'($urandom_range(0, 1));
        step();
        rx_valid = 1'b0;
      end
    end
    tready = 1'b1;
    repeat (20) step();
    check("t6_beats", n_beats - b0, 1000);
    check("t6_drop_cnt", drop_cnt, 16'd0);
    check("t6_level", level, 5'd0);

    // Reset mid-stream with a byte in the reset cycle.
    tready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(8'h30 + i));
    check("t7_level_pre", level, 5'd5);
    rst = 1'b1;
    send(8'h77);
    rst = 1'b0;
    check("t7_rst_tvalid", tvalid, 1'b0);
    check("t7_rst_level", level, 5'd0);
    send(8'h55);
    check("t7_tdata", tdata, 8'h55);
    check("t7_level1", level, 5'd1);
    tready = 1'b1;
    step();
    check("t7_alone", tvalid, 1'b0);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis_bridge.md
# uart_rx_axis_bridge

Downstream stage of the UART receiver: captures each single-cycle `rx_valid`/`rx_data` pulse into a synchronous FIFO and presents the bytes as an AXI4-Stream master. Marks packet ends via `tlast` on a configurable delimiter byte. Tracks overflow when the sink stalls long enough to fill the FIFO. Sits between the receiver and the AXIS consumer (loopback or TX path).

## Interface
- `DATA_BITS`, 8, width of a received character and of `m_axis_tdata`
- `FIFO_DEPTH`, 16, entries; power of two, ≥ 2
- `DELIM`, 8'h0A, byte value that sets `tlast` on its own beat
- `DELIM_EN`, 1, 0 forces `tlast` = 0 on every beat
- `clk` in 1: single clock for all logic
- `rst` in 1: synchronous, active-high reset
- `rx_data` in DATA_BITS: byte from the receiver, qualified by `rx_valid`
- `rx_valid` in 1: one-cycle strobe, new byte; no ready back to the receiver
- `m_axis_tdata` out DATA_BITS: stream data
- `m_axis_tvalid` out 1: stream valid
- `m_axis_tready` in 1: sink ready
- `m_axis_tlast` out 1: beat is the delimiter byte
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current occupancy, 0..FIFO_DEPTH
- `overflow` out 1: sticky, a byte was dropped
- `ovf_clr` in 1: one-cycle clear of `overflow` and `drop_cnt`
- `drop_cnt` out 16: count of dropped bytes, saturates at 16'hFFFF

## Operation
- Each FIFO entry is {tlast, data}, DATA_BITS+1 bits.
- `tlast` is computed at write time as `DELIM_EN && rx_data == DELIM`.
- Write on `rx_valid`. Accept if not full, or if full and a pop occurs in the same cycle (slot freed).
- Otherwise drop the byte: `overflow` ← 1; `drop_cnt` +1, saturating.
- Pop on `m_axis_tvalid && m_axis_tready`.
- The FIFO is first-word-fall-through: the head entry drives `tdata`/`tlast` directly from registered storage.
- `m_axis_tvalid` = (level ≠ 0).
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Level is tracked by a separate counter: +1 on write only, −1 on pop only, unchanged on both.
- `ovf_clr` coinciding with a drop: the drop wins. `overflow` = 1, `drop_cnt` = 1.
- AXIS rule: once `tvalid` is high, `tdata`/`tlast` hold stable until the handshake. The head never changes without a pop.
- Reset outputs:
  - `m_axis_tvalid` = 0, `fifo_level` = 0, `overflow` = 0, `drop_cnt` = 0.
  - `m_axis_tdata` and `m_axis_tlast` are don't-care while `tvalid` = 0. The bench checks them only when `tvalid` = 1.
- `rst` mid-stream: all buffered bytes are discarded, pointers go to 0, and no beat is presented the cycle after reset. An `rx_valid` in the reset cycle is ignored.

## Timing
- `rx_valid` at cycle N into an empty FIFO → `m_axis_tvalid` = 1 with that byte at cycle N+1. Latency is 1 clk.
- Pop at cycle N → next entry (or `tvalid` = 0) at N+1.
- With `tready` held high, sustained throughput is 1 beat per clk. This far exceeds the UART byte rate.
- `fifo_level`, `overflow` and `drop_cnt` are registered and reflect the edge at cycle N from N+1.
- Full with write and pop in the same cycle: level stays FIFO_DEPTH, no drop.
- Empty with write: no pop is possible in that cycle because `tvalid` = 0.

## Structure
- Package `uart_axis_pkg`: default `DATA_BITS`, `DELIM`, and `DROP_CNT_W` = 16, shared with the TX-side adapter.
- Sub-module `sync_fifo_fwft` (parameters WIDTH, DEPTH): storage, pointers, level, full/empty. It is reused by the TX path.
- Top level holds the delimiter compare, the drop logic and the counters.

## Test plan
- Reset, then `rx_valid` with 8'h41 and `tready` = 1 → next clk: `tvalid` = 1, `tdata` = 8'h41, `tlast` = 0; the clk after, `tvalid` = 0 and `fifo_level` = 0.
- Bytes 8'h48, 8'h69, 8'h0A → three beats in order, `tlast` = 1 only on 8'h0A. With `DELIM_EN` = 0 → `tlast` = 0 on all three.
- `tready` = 0 and 17 writes of 8'h00..8'h10 (depth 16) → `fifo_level` = 16, `overflow` = 1, `drop_cnt` = 1. Releasing `tready` drains 8'h00..8'h0F, with `tdata` stable throughout the stall.
- FIFO full, `rx_valid` with 8'hAA and a handshake in the same cycle → no drop, `fifo_level` stays 16, 8'hAA emerges last. Then `ovf_clr` alone → `overflow` = 0, `drop_cnt` = 0.
- Random `tready` (~50%) over 1000 bytes at rate ≤ 1/4 clk → output sequence equals input sequence, `drop_cnt` = 0, AXIS stability never violated.
- 5 bytes buffered, `rst` for 1 clk (with `rx_valid` in the same cycle) → `tvalid` = 0 and `fifo_level` = 0 after reset. A new byte 8'h55 is delivered alone.
